// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width and FIFO geometry helpers.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_RTS_MARGIN = 4;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for the receive FIFO.
module fifo_ptr_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    input  logic                  i_rd_ready,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_in_ready
);

    localparam int PW = fifo_ptr_width(ADDR_WIDTH);

    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_in_ready;

    logic [PW-1:0]       w_wr_ptr_nxt;
    logic [PW-1:0]       w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0] w_count_nxt;
    logic                w_full_nxt;
    logic                w_empty_nxt;
    logic                w_wr_en;
    logic                w_rd_en;

    // Accept handshakes from registered flags only, then derive next pointers and flags.
    always_comb begin
        w_wr_en      = i_wr_valid & r_in_ready;
        w_rd_en      = i_rd_ready & ~r_empty;
        w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_en);
        w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_en);
        w_count_nxt  = r_count + (ADDR_WIDTH+1)'(w_wr_en) - (ADDR_WIDTH+1)'(w_rd_en);
        w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt   = (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                       (w_wr_ptr_nxt[PW-2:0] == w_rd_ptr_nxt[PW-2:0]);
    end

    // State register; input ready stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_in_ready <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_full     <= w_full_nxt;
            r_empty    <= w_empty_nxt;
            r_in_ready <= ~w_full_nxt;
        end
    end

    assign o_wr_en    = w_wr_en;
    assign o_rd_en    = w_rd_en;
    assign o_wr_addr  = r_wr_ptr[PW-2:0];
    assign o_rd_addr  = r_rd_ptr[PW-2:0];
    assign o_count    = r_count;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_in_ready = r_in_ready;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO with registered head output and RTS flow control.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int RTS_MARGIN = FIFO_RTS_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rts_n,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] RTS_LEVEL = (ADDR_WIDTH+1)'(DEPTH - RTS_MARGIN);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_rts_n;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_head_next_addr;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_in_ready;

    fifo_ptr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (input_axis_tvalid),
        .i_rd_ready (output_axis_tready),
        .o_wr_en    (w_wr_en),
        .o_rd_en    (w_rd_en),
        .o_wr_addr  (w_wr_addr),
        .o_rd_addr  (w_rd_addr),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_in_ready (w_in_ready)
    );

    assign w_head_next_addr = w_rd_addr + ADDR_WIDTH'(1);

    // Storage write port; contents are left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= input_axis_tdata;
        end
    end

    // Head register: bypass the incoming byte when it becomes the new head, else prefetch the next entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_data <= '0;
        end else if (w_wr_en && (w_empty || (w_rd_en && (w_count == COUNT_ONE)))) begin
            r_out_data <= input_axis_tdata;
        end else if (w_rd_en && (w_count > COUNT_ONE)) begin
            r_out_data <= r_mem[w_head_next_addr];
        end
    end

    // RTS follows the occupancy seen one cycle earlier so it never depends on same-cycle handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rts_n <= 1'b0;
        end else begin
            r_rts_n <= (w_count >= RTS_LEVEL);
        end
    end

    assign input_axis_tready  = w_in_ready;
    assign output_axis_tdata  = r_out_data;
    assign output_axis_tvalid = ~w_empty;
    assign count              = w_count;
    assign rts_n              = r_rts_n;
    assign full               = w_full;
    assign empty              = w_empty;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width matching the UART data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4; DEPTH = 2^ADDR_WIDTH entries (16).
REQ-003 SHALL have parameter RTS_MARGIN, default 4; free-entry threshold for hardware flow control; legal range 1..DEPTH-1.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-006 input_axis_tdata  input  DATA_WIDTH  received byte from the UART receive side.
REQ-007 input_axis_tvalid  input  1  upstream byte valid.
REQ-008 input_axis_tready  output  1  FIFO can accept a byte.
REQ-009 output_axis_tdata  output  DATA_WIDTH  head byte.
REQ-010 output_axis_tvalid  output  1  head byte valid.
REQ-011 output_axis_tready  input  1  consumer accepts head byte.
REQ-012 count  output  ADDR_WIDTH+1  bytes currently held, 0..DEPTH.
REQ-013 rts_n  output  1  active-low request-to-send; high means "stop sending".
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.

Function
REQ-016 Write accepted in a cycle iff input_axis_tvalid and input_axis_tready are both high.
REQ-017 Read accepted in a cycle iff output_axis_tvalid and output_axis_tready are both high.
REQ-018 input_axis_tready SHALL equal ~full, derived from registered state only; no combinational path from output_axis_tready.
REQ-019 Full plus simultaneous read: write not accepted that cycle; input_axis_tready rises the next cycle.
REQ-020 output_axis_tdata and output_axis_tvalid SHALL be registered.
REQ-021 Byte written into an empty FIFO in cycle N SHALL appear with output_axis_tvalid high in cycle N+1.
REQ-022 output_axis_tvalid SHALL equal ~empty.
REQ-023 Byte order SHALL be strictly FIFO; output_axis_tdata SHALL stay stable while output_axis_tvalid is high and output_axis_tready is low.
REQ-024 Simultaneous write and read with 0 < count < DEPTH: count unchanged, both transfers complete.
REQ-025 Simultaneous write and read at count == 1: head advances to the new byte in the next cycle; output_axis_tvalid stays high.
REQ-026 Count update: +1 on write only, -1 on read only, otherwise unchanged.
REQ-027 Read and write pointers SHALL be ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
REQ-028 Full/empty SHALL be decided by MSB inversion with equal lower bits.
REQ-029 rts_n SHALL be registered and go high in the cycle after count becomes >= DEPTH-RTS_MARGIN.
REQ-030 rts_n SHALL go low in the cycle after count becomes < DEPTH-RTS_MARGIN.
REQ-031 Reads when empty and writes when full SHALL be ignored, with no state change.

Reset
REQ-032 While rst is low at a clock edge: pointers and count = 0, output_axis_tvalid = 0, output_axis_tdata = 0, input_axis_tready = 0, empty = 1, full = 0, rts_n = 0.
REQ-033 input_axis_tready SHALL go high on the first clock edge after rst is sampled high.
REQ-034 Reset asserted mid-stream SHALL discard all stored bytes, including a head byte that is being presented.
REQ-035 Storage array contents need not be reset.

Structure
REQ-036 Memory SHALL be a DEPTH x DATA_WIDTH array inferable as distributed RAM.
REQ-037 DEPTH and the pointer-width derivation SHALL live in a shared package uart_pkg, with the UART data width constant.
REQ-038 A single sub-module, fifo_ptr_ctrl, SHALL hold the pointers, count, and full/empty logic; no other hierarchy.

Verification
REQ-039 Reset then write 0xA5 in one cycle: output_axis_tvalid high with 0xA5 next cycle; count = 1; rts_n = 0.
REQ-040 Output tready low, write 16 bytes 0x00..0x0F: full = 1, input_axis_tready = 0, rts_n high from count 12; then read all 16 bytes back in order 0x00..0x0F.
REQ-041 Full FIFO with a 17th tvalid held and tready asserted for one cycle: exactly one byte out; 17th byte accepted on the following cycle; count = 16.
REQ-042 Continuous write and read at count 1 for 100 cycles: count stays 1; output sequence equals input sequence; pointers wrap cleanly.
REQ-043 rst low at count 9 while output_axis_tvalid is high: next cycle count = 0, output_axis_tvalid = 0, input_axis_tready = 0; normal operation after release.
REQ-044 Random tvalid/tready at 50% each for 10k cycles against a scoreboard: no loss, duplication, or reorder; count always matches the model.
